// File: rtl/redstone_pkg.sv
// Shared types and helpers for the redstone netlist cells.
package redstone_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } state_e;

  localparam int DEFAULT_MAX_DELAY = 4;

  // Delay code width, never narrower than one bit.
  function automatic int delay_width(input int max_delay);
    return (max_delay <= 2) ? 1 : $clog2(max_delay);
  endfunction

endpackage

// File: rtl/repeater_channel.sv
// One redstone repeater: programmable k+1 tick delay with pulse extension.
// Optional lock input enabled by `define REPEATER_LOCK_EN.
module repeater_channel
  import redstone_pkg::*;
#(
  parameter int   MAX_DELAY = DEFAULT_MAX_DELAY,
  parameter int   DW        = delay_width(MAX_DELAY),
  parameter logic INIT      = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_in,
  input  logic [DW-1:0] i_delay,
`ifdef REPEATER_LOCK_EN
  input  logic          i_lock,
`endif
  output logic          o_out
);

  localparam logic [DW:0]   MAX_EXT = (DW+1)'(MAX_DELAY);
  localparam logic [DW-1:0] K_MAX   = DW'(MAX_DELAY - 1);

  state_e        state_q, state_d;
  logic          out_q, out_d;
  logic          tgt_q, tgt_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] k_clamped;

  always_comb begin
    k_clamped = ({1'b0, i_delay} >= MAX_EXT) ? K_MAX : i_delay;
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
`ifdef REPEATER_LOCK_EN
    // Lock aborts any pending transition and freezes the output.
    if (i_lock) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else
`endif
    begin
      case (state_q)
        ST_IDLE: begin
          if (i_in != out_q) begin
            tgt_d   = i_in;
            cnt_d   = k_clamped;
            state_d = ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DW'(1);
          end else begin
            out_d   = tgt_q;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      out_q   <= INIT;
      tgt_q   <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_out = out_q;

endmodule

// File: rtl/repeater_bank.sv
// Bank of CHANNELS independent redstone repeaters sharing the game tick.
// Lock port present only with `define REPEATER_LOCK_EN.
module repeater_bank
  import redstone_pkg::*;
#(
  parameter int                  CHANNELS  = 8,
  parameter int                  MAX_DELAY = DEFAULT_MAX_DELAY,
  parameter logic [CHANNELS-1:0] INIT      = '0,
  localparam int                 DW        = delay_width(MAX_DELAY)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [CHANNELS-1:0]    i_in,
  input  logic [CHANNELS*DW-1:0] i_delay,
`ifdef REPEATER_LOCK_EN
  input  logic [CHANNELS-1:0]    i_lock,
`endif
  output logic [CHANNELS-1:0]    o_out
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    repeater_channel #(
      .MAX_DELAY (MAX_DELAY),
      .DW        (DW),
      .INIT      (INIT[c])
    ) u_ch (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_in    (i_in[c]),
      .i_delay (i_delay[c*DW +: DW]),
`ifdef REPEATER_LOCK_EN
      .i_lock  (i_lock[c]),
`endif
      .o_out   (o_out[c])
    );
  end

endmodule
